// File: rtl/jtframe_2308_scan.sv
// LTC2308 round-robin scan controller with a priority request port and an 8x12 result bank.
// Define JTFRAME_2308_AVG_EN to make the bank keep a running average instead of raw samples.
module jtframe_2308_scan #(
   parameter int unsigned CONV_CYC = 40,
   parameter bit          UNI      = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic [7:0]  ch_en,
   input  logic        req,
   input  logic [2:0]  req_ch,
   output logic        ack,
   output logic        adc_convst,
   output logic        adc_sck,
   output logic        adc_sdi,
   input  logic        adc_sdo,
   output logic [11:0] dout,
   output logic [2:0]  dout_ch,
   output logic        dout_valid,
   input  logic [2:0]  rd_ch,
   output logic [11:0] rd_data
);

   localparam logic [2:0] IDLE  = 3'd0,
                          CONV  = 3'd1,
                          SETUP = 3'd2,
                          SHIFT = 3'd3,
                          DONE  = 3'd4;

   logic [2:0]  st, rr, cfg_ch, pend_ch;
   logic        pend_vld;
   logic [15:0] cnt;
   logic [3:0]  bitcnt;
   logic [11:0] sreg;
   logic [11:0] bank [8];
   logic [11:0] bank_wr;
   logic [5:0]  cfg_word;
   logic        rr_found, sched_ok, start;
   logic [2:0]  rr_ch, rr_idx, sched_ch;

   assign cfg_word = {1'b1, cfg_ch[0], cfg_ch[2], cfg_ch[1], UNI, 1'b0};
   assign rd_data  = bank[rd_ch];

   // First enabled channel strictly after rr; i=8 wraps back onto rr itself
   always_comb begin
      rr_found = 1'b0;
      rr_ch    = rr;
      rr_idx   = rr;
      for (int i = 1; i <= 8; i++) begin
         rr_idx = rr + 3'(i);
         if (!rr_found && ch_en[rr_idx]) begin
            rr_found = 1'b1;
            rr_ch    = rr_idx;
         end
      end
   end

   assign sched_ok = req | rr_found;
   assign sched_ch = req ? req_ch : rr_ch;
   assign start    = cen && sched_ok && (st == IDLE || st == DONE);

`ifdef JTFRAME_2308_AVG_EN
   logic [7:0]  seen;
   logic [13:0] avg_sum;
   always_comb begin
      avg_sum = 14'(bank[pend_ch]) * 14'd3 + 14'(sreg);
      bank_wr = seen[pend_ch] ? avg_sum[13:2] : sreg;
   end
`else
   assign bank_wr = sreg;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= IDLE;
         rr         <= 3'd7;
         cfg_ch     <= '0;
         pend_ch    <= '0;
         pend_vld   <= 1'b0;
         cnt        <= '0;
         bitcnt     <= '0;
         sreg       <= '0;
         ack        <= 1'b0;
         adc_convst <= 1'b0;
         adc_sck    <= 1'b0;
         adc_sdi    <= 1'b0;
         dout       <= '0;
         dout_ch    <= '0;
         dout_valid <= 1'b0;
         for (int i = 0; i < 8; i++) bank[i] <= '0;
`ifdef JTFRAME_2308_AVG_EN
         seen       <= '0;
`endif
      end else begin
         ack        <= 1'b0;
         dout_valid <= 1'b0;
         if (cen) begin
            case (st)
               CONV: begin
                  if (cnt == 16'(CONV_CYC - 1)) begin
                     adc_convst <= 1'b0;
                     st         <= SETUP;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               SETUP: begin
                  adc_sdi <= cfg_word[5];
                  adc_sck <= 1'b0;
                  bitcnt  <= '0;
                  st      <= SHIFT;
               end
               SHIFT: begin
                  if (!adc_sck) begin
                     adc_sck <= 1'b1;
                     sreg    <= {sreg[10:0], adc_sdo};
                     bitcnt  <= bitcnt + 4'd1;
                  end else begin
                     adc_sck <= 1'b0;
                     if (bitcnt == 4'd12) begin
                        adc_sdi <= 1'b0;
                        st      <= DONE;
                     end else begin
                        adc_sdi <= (bitcnt < 4'd6) ? cfg_word[3'(4'd5 - bitcnt)] : 1'b0;
                     end
                  end
               end
               DONE: begin
                  if (pend_vld) begin
                     bank[pend_ch] <= bank_wr;
                     dout          <= sreg;
                     dout_ch       <= pend_ch;
                     dout_valid    <= 1'b1;
`ifdef JTFRAME_2308_AVG_EN
                     seen[pend_ch] <= 1'b1;
`endif
                  end
                  pend_ch  <= cfg_ch;
                  pend_vld <= 1'b1;
                  st       <= IDLE;
               end
               default: st <= IDLE;
            endcase
            // A scheduling hit overrides the IDLE fall-back set above
            if (start) begin
               st         <= CONV;
               adc_convst <= 1'b1;
               cnt        <= '0;
               cfg_ch     <= sched_ch;
               ack        <= req;
               if (!req) rr <= sched_ch;
            end
         end
      end
   end

endmodule

// File: tb/tb_jtframe_2308_scan.sv
// Bench for jtframe_2308_scan: LTC2308 behavioural model, result scoreboard and vector table.
// Honours JTFRAME_2308_AVG_EN for the expected bank contents.
module tb_jtframe_2308_scan;

   localparam int CONV_CYC = 40;

   logic        clk = 1'b0, rst = 1'b1, cen = 1'b0;
   logic [7:0]  ch_en = '0;
   logic        req = 1'b0;
   logic [2:0]  req_ch = '0, rd_ch = '0;
   logic        ack, adc_convst, adc_sck, adc_sdi, adc_sdo, dout_valid;
   logic [11:0] dout, rd_data;
   logic [2:0]  dout_ch;

   jtframe_2308_scan #(.CONV_CYC(CONV_CYC), .UNI(1'b1)) dut (
      .clk(clk), .rst(rst), .cen(cen), .ch_en(ch_en), .req(req), .req_ch(req_ch),
      .ack(ack), .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi),
      .adc_sdo(adc_sdo), .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid),
      .rd_ch(rd_ch), .rd_data(rd_data)
   );

   always #5 clk = ~clk;
   always @(negedge clk) cen = ~cen;

   int vectors = 0, miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ADC model: config word captured on SCK rise, result shifted MSB first, next bit on SCK fall
   typedef struct packed {logic [2:0] ch; logic [11:0] d;} res_t;
   res_t        sbq[$];
   logic [11:0] val [8];
   logic [11:0] exp_bank [8];
   logic [7:0]  exp_seen = '0;
   logic [5:0]  ltc_cfg = '0, rx_word = '0, last_word = '0;
   logic [11:0] out_word = '0;
   logic [3:0]  bitidx = '0;
   logic [2:0]  conv_ch, last_ch = '0;
   bit          cfg_known = 1'b0;
   int          rx_cnt = 0, rises = 0, n_words = 0, n_res = 0, n_conv = 0, n_ack = 0;
   time         t_rise = 0;

   assign adc_sdo = out_word[bitidx];

   always @(posedge adc_convst) begin
      t_rise   = $time;
      n_conv++;
      conv_ch  = {ltc_cfg[3], ltc_cfg[2], ltc_cfg[4]};
      out_word = val[conv_ch];
      bitidx   = 4'd11;
      if (cfg_known) sbq.push_back({conv_ch, val[conv_ch]});
   end

   always @(negedge adc_convst) if (!rst) begin
      chk("convst_width", 32'(($time - t_rise) / 10), 2 * CONV_CYC);
      rx_cnt = 0;
      rises  = 0;
   end

   always @(negedge adc_sck) if (bitidx != 0) bitidx = bitidx - 4'd1;

   always @(posedge adc_sck) if (!rst) begin
      rises++;
      rx_cnt++;
      if (rx_cnt <= 6) rx_word = {rx_word[4:0], adc_sdi};
      if (rx_cnt == 6) begin
         ltc_cfg   = rx_word;
         last_word = rx_word;
         cfg_known = 1'b1;
         n_words++;
      end
   end

   always @(negedge clk) if (!rst && ack) n_ack++;

   always @(negedge clk) if (!rst && dout_valid) begin
      res_t e;
      n_res++;
      chk("sck_rises", rises, 12);
      if (sbq.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_strobe: got ch%0d %0h expected none", dout_ch, dout);
      end else begin
         e = sbq.pop_front();
         chk("dout_ch", dout_ch, e.ch);
         chk("dout", dout, e.d);
`ifdef JTFRAME_2308_AVG_EN
         if (exp_seen[e.ch]) exp_bank[e.ch] = 12'((3 * int'(exp_bank[e.ch]) + int'(e.d)) >> 2);
         else exp_bank[e.ch] = e.d;
`else
         exp_bank[e.ch] = e.d;
`endif
         exp_seen[e.ch] = 1'b1;
      end
      last_ch = dout_ch;
   end

   function automatic int cur(input int which);
      case (which)
         0:       return n_words;
         1:       return n_res;
         default: return n_conv;
      endcase
   endfunction

   task automatic wait_evt(input int which, input int target);
      int k = 0;
      while (cur(which) < target && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (cur(which) < target) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: event %0d got %0d expected %0d", which, cur(which), target);
      end
   endtask

   task automatic clear_model();
      sbq.delete();
      cfg_known = 1'b0;
      rx_cnt    = 0;
      rises     = 0;
      exp_seen  = '0;
      for (int i = 0; i < 8; i++) exp_bank[i] = '0;
   endtask

   function automatic logic [5:0] cfg_of(input logic [2:0] ch);
      return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_convst"}, adc_convst, 0);
      chk({tag, "_sck"}, adc_sck, 0);
      chk({tag, "_sdi"}, adc_sdi, 0);
      chk({tag, "_ack"}, ack, 0);
      chk({tag, "_dout"}, dout, 0);
      chk({tag, "_dout_ch"}, dout_ch, 0);
      chk({tag, "_dout_valid"}, dout_valid, 0);
   endtask

   typedef struct {
      logic [7:0] ch_en;
      logic       req;
      logic [2:0] req_ch;
      logic [2:0] exp_ch;
   } vec_t;
   vec_t tbl [10];

   initial begin
      int w, a0, r0, c0;
      tbl[0] = '{8'h05, 1'b0, 3'd0, 3'd0};
      tbl[1] = '{8'h05, 1'b0, 3'd0, 3'd2};
      tbl[2] = '{8'h05, 1'b0, 3'd0, 3'd0};
      tbl[3] = '{8'h05, 1'b0, 3'd0, 3'd2};
      tbl[4] = '{8'h81, 1'b0, 3'd0, 3'd7};
      tbl[5] = '{8'h81, 1'b0, 3'd0, 3'd0};  // wrap 7 -> 0
      tbl[6] = '{8'h01, 1'b1, 3'd5, 3'd5};  // priority jump, rr stays at 0
      tbl[7] = '{8'h05, 1'b0, 3'd0, 3'd2};
      tbl[8] = '{8'h05, 1'b0, 3'd0, 3'd0};
      tbl[9] = '{8'h02, 1'b0, 3'd0, 3'd1};
      for (int i = 0; i < 8; i++) val[i] = 12'hA00 + 12'(i);
      clear_model();

      repeat (4) @(negedge clk);
      chk_reset_outputs("rst");
      for (int i = 0; i < 8; i++) begin
         rd_ch = 3'(i);
         #1 chk("rst_bank", rd_data, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("idle_no_en", adc_convst, 0);

      for (int i = 0; i < 10; i++) begin
         ch_en  = tbl[i].ch_en;
         req    = tbl[i].req;
         req_ch = tbl[i].req_ch;
         a0 = n_ack;
         w  = n_words;
         wait_evt(0, w + 1);
         chk("cfg_word", last_word, cfg_of(tbl[i].exp_ch));
         chk("ack_count", n_ack - a0, tbl[i].req ? 1 : 0);
         req = 1'b0;
      end

      // Disable scanning: the in-flight DONE still strobes once, then the FSM idles
      ch_en = 8'h00;
      r0 = n_res;
      repeat (300) @(negedge clk);
      chk("idle_convst", adc_convst, 0);
      chk("idle_results", n_res - r0, 1);
      rd_ch = 3'd2;
      #1 chk("bank_ch2", rd_data, 12'hA02);
      rd_ch = 3'd0;
      #1 chk("bank_ch0", rd_data, 12'hA00);
      for (int i = 0; i < 8; i++) begin
         rd_ch = 3'(i);
         #1 chk("bank_model", rd_data, exp_bank[i]);
      end
      ch_en = 8'h02;
      r0 = n_res;
      wait_evt(1, r0 + 1);
      chk("pending_after_idle", last_ch, 1);

      // Reset in the middle of SHIFT
      w = n_words;
      wait_evt(0, w + 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1 chk_reset_outputs("midrst");
      rd_ch = 3'd1;
      #1 chk("midrst_bank", rd_data, 0);
      clear_model();
      val[1] = 12'h400;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      r0 = n_res;
      c0 = n_conv;
      wait_evt(2, c0 + 2);
      val[1] = 12'h800;
      chk("first_discarded", n_res - r0, 0);
      wait_evt(1, r0 + 1);
      chk("avg_first_dout", dout, 12'h400);
      chk("avg_first_bank", rd_data, 12'h400);
      wait_evt(1, r0 + 2);
      chk("avg_second_dout", dout, 12'h800);
`ifdef JTFRAME_2308_AVG_EN
      chk("avg_second_bank", rd_data, 12'h500);
`else
      chk("avg_second_bank", rd_data, 12'h800);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
